// File: rtl/regsel_pkg.sv
// regsel_pkg: shared field positions, opcodes, write-rule helper and WB entry type
package regsel_pkg;
  localparam int NREG = 32;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  typedef struct packed {
    logic       we;
    logic [4:0] dest;
  } wb_entry_t;
  // R-type, the immediate ALU group 08..0F and lw are the only register writers
  function automatic logic writes_reg(input logic [5:0] op);
    return op == OP_RTYPE || (op >= OP_ADDI && op <= OP_LUI) || op == OP_LW;
  endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: 5-bit register index to N-wide one-hot select
module onehot_dec #(parameter int N = 32) (
  input  logic [4:0]   i_idx,
  output logic [N-1:0] o_sel
);
  assign o_sel = {{(N-1){1'b0}}, 1'b1} << i_idx;
endmodule

// File: rtl/regsel_decode_pipe.sv
// regsel_decode_pipe: register-select decode stage with delayed writeback select.
// Define HAZARD_STALL_EN to enable the RAW interlock; otherwise hazard is tied 0.
module regsel_decode_pipe
  import regsel_pkg::*;
#(parameter int WB_DEPTH = 3) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic            stall_in,
  output logic            instr_ready,
  output logic [NREG-1:0] Aselect,
  output logic [NREG-1:0] Bselect,
  output logic            sel_valid,
  output logic [NREG-1:0] Dselect,
  output logic            hazard
);
  logic [4:0]      r_rs, r_rt, r_dest;
  logic            r_we, r_valid;
  wb_entry_t       r_wb [WB_DEPTH];
  logic [5:0]      w_op;
  logic [4:0]      w_dest;
  logic            w_hazard;
  logic [NREG-1:0] w_dsel;
  logic            w_unused;
  assign w_op        = instr[OP_HI:OP_LO];
  assign w_dest      = w_op == OP_RTYPE ? instr[RD_HI:RD_LO] : instr[RT_HI:RT_LO];
  assign w_unused    = ^instr[RD_LO-1:0];
  assign instr_ready = ~stall_in & ~w_hazard;
  assign sel_valid   = r_valid & ~w_hazard;
  assign hazard      = w_hazard;
`ifdef HAZARD_STALL_EN
  logic w_hit;
  // any pending writer in the WB pipe whose destination this instruction reads
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++)
      w_hit |= r_wb[i].we && r_wb[i].dest != '0 && (r_wb[i].dest == r_rs || r_wb[i].dest == r_rt);
  end
  assign w_hazard = r_valid & w_hit;
`else
  assign w_hazard = 1'b0;
`endif
  // decode register: load on transfer, drop valid on an empty ready cycle, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs    <= '0;
      r_rt    <= '0;
      r_dest  <= '0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
    end else if (instr_ready) begin
      r_valid <= instr_valid;
      if (instr_valid) begin
        r_rs   <= instr[RS_HI:RS_LO];
        r_rt   <= instr[RT_HI:RT_LO];
        r_dest <= w_dest;
        r_we   <= writes_reg(w_op) && w_dest != '0;
      end
    end
  end
  // WB pipe: the decoded instruction enters once as it leaves D, bubbles otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_DEPTH; i++) r_wb[i] <= '0;
    end else begin
      r_wb[0] <= instr_ready ? {r_valid & r_we, r_dest} : '0;
      for (int i = 1; i < WB_DEPTH; i++) r_wb[i] <= r_wb[i-1];
    end
  end
  onehot_dec #(.N(NREG)) u_a (.i_idx(r_rs), .o_sel(Aselect));
  onehot_dec #(.N(NREG)) u_b (.i_idx(r_rt), .o_sel(Bselect));
  onehot_dec #(.N(NREG)) u_d (.i_idx(r_wb[WB_DEPTH-1].dest), .o_sel(w_dsel));
  assign Dselect = r_wb[WB_DEPTH-1].we ? w_dsel : '0;
endmodule

// File: tb/tb_regsel_decode_pipe.sv
// tb_regsel_decode_pipe: vector table, corner sequences and random run against a queue model
module tb_regsel_decode_pipe;
  localparam int WB_DEPTH = 3;
`ifdef HAZARD_STALL_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif
  logic        clk, rst_n, instr_valid, stall_in;
  logic [31:0] instr;
  logic        instr_ready, sel_valid, hazard;
  logic [31:0] Aselect, Bselect, Dselect;

  regsel_decode_pipe #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .instr_ready(instr_ready), .Aselect(Aselect),
    .Bselect(Bselect), .sel_valid(sel_valid), .Dselect(Dselect), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // model: current decoded instruction plus a queue of pending write destinations (0 = none)
  int m_rs, m_rt, m_wd;
  bit m_live;
  int m_wb[$];

  function automatic void m_reset();
    m_rs = 0; m_rt = 0; m_wd = 0; m_live = 0;
    m_wb.delete();
    for (int i = 0; i < WB_DEPTH; i++) m_wb.push_back(0);
  endfunction

  function automatic int wdest_of(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h00) return int'(w[15:11]);
    if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) return int'(w[20:16]);
    return 0;
  endfunction

  function automatic bit m_haz();
    if (!HAZ || !m_live) return 1'b0;
    foreach (m_wb[i]) if (m_wb[i] != 0 && (m_wb[i] == m_rs || m_wb[i] == m_rt)) return 1'b1;
    return 1'b0;
  endfunction

  // entered at posedge+1: drive, compare against model mid-cycle, take the edge, advance model
  task automatic cycle(input logic v, input logic [31:0] w, input logic st);
    bit rdy;
    int last;
    instr_valid = v; instr = w; stall_in = st;
    #3;
    rdy  = !st && !m_haz();
    last = m_wb[WB_DEPTH-1];
    chk("ready", 32'(instr_ready), 32'(rdy));
    chk("hazard", 32'(hazard), 32'(m_haz()));
    chk("asel", Aselect, 32'd1 << m_rs);
    chk("bsel", Bselect, 32'd1 << m_rt);
    chk("sel_valid", 32'(sel_valid), 32'(m_live && !m_haz()));
    chk("dsel", Dselect, last != 0 ? 32'd1 << last : 32'd0);
    @(posedge clk);
    m_wb.push_front((rdy && m_live) ? m_wd : 0);
    void'(m_wb.pop_back());
    if (rdy) begin
      if (v) begin
        m_rs = int'(w[25:21]);
        m_rt = int'(w[20:16]);
        m_wd = wdest_of(w);
      end
      m_live = v;
    end
    #1;
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_asel"}, Aselect, 32'h1);
    chk({nm, "_bsel"}, Bselect, 32'h1);
    chk({nm, "_dsel"}, Dselect, 32'h0);
    chk({nm, "_sv"}, 32'(sel_valid), 32'h0);
    chk({nm, "_hazard"}, 32'(hazard), 32'h0);
    chk({nm, "_ready"}, 32'(instr_ready), 32'h1);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] w;
    logic [31:0] a, b, d;
    logic        sv;
  } vec_t;
  vec_t tbl[16];

  logic [5:0] ops[10];
  int pulses, hcnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h00221820, 32'h2,  32'h4,  32'h0,  1'b1};
    tbl[1]  = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h0,  1'b0};
    tbl[2]  = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h0,  1'b0};
    tbl[3]  = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h8,  1'b0};
    tbl[4]  = '{1'b1, 32'h8C850000, 32'h10, 32'h20, 32'h0,  1'b1};
    tbl[5]  = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h0,  1'b0};
    tbl[6]  = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h0,  1'b0};
    tbl[7]  = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h20, 1'b0};
    tbl[8]  = '{1'b1, 32'hAC850000, 32'h10, 32'h20, 32'h0,  1'b1};
    tbl[9]  = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h0,  1'b0};
    tbl[10] = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h0,  1'b0};
    tbl[11] = '{1'b0, 32'h0,        32'h10, 32'h20, 32'h0,  1'b0};
    tbl[12] = '{1'b1, 32'h00220020, 32'h2,  32'h4,  32'h0,  1'b1};
    tbl[13] = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h0,  1'b0};
    tbl[14] = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h0,  1'b0};
    tbl[15] = '{1'b0, 32'h0,        32'h2,  32'h4,  32'h0,  1'b0};
    ops = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

    rst_n = 1'b1; instr_valid = 1'b0; instr = '0; stall_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check("reset");
    m_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].w, 1'b0);
      chk($sformatf("vec%0d_asel", i), Aselect, tbl[i].a);
      chk($sformatf("vec%0d_bsel", i), Bselect, tbl[i].b);
      chk($sformatf("vec%0d_dsel", i), Dselect, tbl[i].d);
      chk($sformatf("vec%0d_sv", i), 32'(sel_valid), 32'(tbl[i].sv));
    end

    pulses = 0;
    cycle(1'b1, 32'h00221820, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (Dselect == 32'h8) pulses++;
    end
    chk("stall_asel", Aselect, 32'h2);
    chk("stall_sv", 32'(sel_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (Dselect == 32'h8) pulses++;
    end
    chk("stall_pulses", 32'(pulses), 32'd1);

    cycle(1'b1, 32'h00221820, 1'b0);
    cycle(1'b1, 32'h00632020, 1'b0);
    hcnt = 0;
    for (int i = 0; i < 10 && hazard; i++) begin
      if (!instr_ready) hcnt++;
      cycle(1'b0, 32'h0, 1'b0);
    end
    chk("raw_hazard_cycles", 32'(hcnt), HAZ ? 32'd3 : 32'd0);
    chk("raw_asel", Aselect, 32'h8);
    chk("raw_bsel", Bselect, 32'h8);
    chk("raw_sv", 32'(sel_valid), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 11'($urandom)};
      cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 4) == 0));
    end

    cycle(1'b1, 32'h00221820, 1'b0);
    instr_valid = 1'b0; stall_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check("midreset");
    m_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
